// File: rtl/mem_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// mem_rmw_sequencer
//
// Request-side sequencer for the erasable/fixed memory port. It accepts one
// command at a time (READ, WRITE, INCR, ADS) and runs it as a short
// read/modify/write sequence, ending with a one-cycle done pulse. This block is
// the only driver of the memory write enable.
//
// Optional feature: define MEM_REGGUARD_EN to block writes to the CPU-register
// mirror (addresses 0x000-0x00F). Guarded writes still run to completion, with
// err_o set and no write enable.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_i                command request, sampled only while idle
//   cmd_i                0 READ, 1 WRITE, 2 INCR, 3 ADS
//   addr_i               target address
//   operand_i            WRITE data or ADS addend
//   opcode_in_i          bank-mapping opcode forwarded to memory
//   busy_o               high whenever not idle
//   done_o               one-cycle completion pulse
//   rdata_o              read value / written-back value, held until next accept
//   ovf_o                ones-complement overflow of INCR/ADS
//   err_o                write rejected by the register guard
//   mem_address_o        address presented to memory
//   mem_opcode_o         opcode presented to memory
//   mem_data_out_o       write data to memory (0 when not writing)
//   mem_write_enable_o   memory write enable
//   mem_result_i         memory read data (combinational from the address)
// -----------------------------------------------------------------------------
module mem_rmw_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [1:0]        cmd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [2:0]        opcode_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ovf_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [2:0]        mem_opcode_o,
  output logic [DATA_W-1:0] mem_data_out_o,
  output logic              mem_write_enable_o,
  input  logic [DATA_W-1:0] mem_result_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WBACK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_INCR  = 2'd2;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;   // doubles as the read register
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              write_blocked;
  logic [DATA_W-1:0] write_data;

  // Ones-complement adder: end-around carry folds bit DATA_W back into bit 0.
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   raw_sum;
  logic [DATA_W-1:0] sum;
  logic              sum_ovf;

  assign addend  = (cmd_q == CMD_INCR) ? {{(DATA_W-1){1'b0}}, 1'b1} : operand_q;
  assign raw_sum = {1'b0, rdata_q} + {1'b0, addend};
  assign sum     = raw_sum[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, raw_sum[DATA_W]};
  assign sum_ovf = (rdata_q[DATA_W-1] == addend[DATA_W-1]) &&
                   (sum[DATA_W-1] != rdata_q[DATA_W-1]);

`ifdef MEM_REGGUARD_EN
  // The low 16 words mirror CPU registers and are rewritten by memory every
  // cycle, so any write there would be lost; READ is never blocked.
  assign write_blocked = (cmd_q != CMD_READ) && (addr_q[ADDR_W-1:4] == '0);
`else
  assign write_blocked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_READ;
      addr_q    <= '0;
      operand_q <= '0;
      opcode_q  <= '0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      opcode_q  <= opcode_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  // Write enable is decoded from registered state only, so an asynchronous
  // reset removes it immediately.
  always_comb begin
    state_d            = state_q;
    cmd_d              = cmd_q;
    addr_d             = addr_q;
    operand_d          = operand_q;
    opcode_d           = opcode_q;
    rdata_d            = rdata_q;
    ovf_d              = ovf_q;
    err_d              = err_q;
    mem_write_enable_o = 1'b0;
    write_data         = '0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cmd_d     = cmd_i;
          addr_d    = addr_i;
          operand_d = operand_i;
          opcode_d  = opcode_in_i;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        err_d = write_blocked;
        if (cmd_q == CMD_WRITE) begin
          mem_write_enable_o = !write_blocked;
          write_data         = operand_q;
          state_d            = S_DONE;
        end else begin
          rdata_d = mem_result_i;
          state_d = (cmd_q == CMD_READ) ? S_DONE : S_WBACK;
        end
      end
      S_WBACK: begin
        mem_write_enable_o = !write_blocked;
        write_data         = sum;
        rdata_d            = sum;
        ovf_d              = sum_ovf;
        state_d            = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_data_out_o = mem_write_enable_o ? write_data : '0;
  assign mem_address_o  = addr_q;
  assign mem_opcode_o   = opcode_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign rdata_o        = rdata_q;
  assign ovf_o          = ovf_q;
  assign err_o          = err_q;

endmodule
